// File: rtl/cv32e40s_pkg.sv
// rtl/cv32e40s_pkg.sv - ALU opcode encodings and SHA-256 sigma selects
package cv32e40s_pkg;

  typedef enum logic [5:0] {
    ALU_LT         = 6'b000000,
    ALU_LTU        = 6'b000001,
    ALU_SLT        = 6'b000010,
    ALU_SLTU       = 6'b000011,
    ALU_GE         = 6'b001010,
    ALU_GEU        = 6'b001011,
    ALU_EQ         = 6'b001100,
    ALU_NE         = 6'b001101,
    ALU_AND        = 6'b010101,
    ALU_ADD        = 6'b011000,
    ALU_SUB        = 6'b011001,
    ALU_SRA        = 6'b100100,
    ALU_SRL        = 6'b100101,
    ALU_SLL        = 6'b100111,
    ALU_OR         = 6'b101110,
    ALU_XOR        = 6'b101111,
    ALU_SHA256SUM0 = 6'b110110,
    ALU_SHA256SUM1 = 6'b111010,
    ALU_SHA256SIG0 = 6'b111011,
    ALU_SHA256SIG1 = 6'b111111
  } alu_opcode_e;

  typedef enum logic [1:0] {
    SHA_SUM0 = 2'd0,
    SHA_SUM1 = 2'd1,
    SHA_SIG0 = 2'd2,
    SHA_SIG1 = 2'd3
  } sha256_sel_e;

endpackage

// File: rtl/cv32e40s_alu_sha256.sv
// rtl/cv32e40s_alu_sha256.sv - SHA-256 Sigma/sigma functions on one 32-bit word
module cv32e40s_alu_sha256
  import cv32e40s_pkg::*;
(
  input  logic [31:0] operand_i,
  input  logic [1:0]  sel_i,
  output logic [31:0] result_o
);

  logic [31:0] a;
  assign a = operand_i;

  // Rotates are pure rewiring; shr fills with zeros from the top
  always_comb begin
    result_o = 32'h0;
    case (sel_i)
      SHA_SUM0: result_o = {a[1:0],  a[31:2]}  ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
      SHA_SUM1: result_o = {a[5:0],  a[31:6]}  ^ {a[10:0], a[31:11]} ^ {a[24:0], a[31:25]};
      SHA_SIG0: result_o = {a[6:0],  a[31:7]}  ^ {a[17:0], a[31:18]} ^ {3'b000, a[31:3]};
      SHA_SIG1: result_o = {a[16:0], a[31:17]} ^ {a[18:0], a[31:19]} ^ {10'b0, a[31:10]};
      default:  result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/cv32e40s_alu.sv
// rtl/cv32e40s_alu.sv - combinational ALU with SHA-256 ops and divider helpers
module cv32e40s_alu
  import cv32e40s_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [31:0] muldiv_operand_b_i,
  input  logic        div_clz_en_i,
  input  logic [31:0] div_clz_data_rev_i,
  input  logic        div_shift_en_i,
  input  logic [5:0]  div_shift_amt_i,
  output logic [31:0] result_o,
  output logic        cmp_result_o,
  output logic [5:0]  div_clz_result_o,
  output logic [31:0] div_op_b_shifted_o
);

  // Clock and reset exist only for port uniformity; nothing here is stateful
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  function automatic logic [5:0] trailing_zeros(input logic [31:0] d);
    trailing_zeros = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (d[i]) trailing_zeros = 6'(i);
    end
  endfunction

  logic        lt_signed;
  logic        lt_unsigned;
  logic        equal;
  logic [4:0]  shamt;
  logic [31:0] sha_result;
  sha256_sel_e sha_sel;

  assign lt_signed   = $signed(operand_a_i) < $signed(operand_b_i);
  assign lt_unsigned = operand_a_i < operand_b_i;
  assign equal       = operand_a_i == operand_b_i;
  assign shamt       = operand_b_i[4:0];

  always_comb begin
    sha_sel = SHA_SUM0;
    case (operator_i)
      ALU_SHA256SUM1: sha_sel = SHA_SUM1;
      ALU_SHA256SIG0: sha_sel = SHA_SIG0;
      ALU_SHA256SIG1: sha_sel = SHA_SIG1;
      default:        sha_sel = SHA_SUM0;
    endcase
  end

  cv32e40s_alu_sha256 u_sha256 (
    .operand_i (operand_a_i),
    .sel_i     (sha_sel),
    .result_o  (sha_result)
  );

  always_comb begin
    cmp_result_o = 1'b0;
    case (operator_i)
      ALU_LT,  ALU_SLT:  cmp_result_o = lt_signed;
      ALU_LTU, ALU_SLTU: cmp_result_o = lt_unsigned;
      ALU_GE:            cmp_result_o = ~lt_signed;
      ALU_GEU:           cmp_result_o = ~lt_unsigned;
      ALU_EQ:            cmp_result_o = equal;
      ALU_NE:            cmp_result_o = ~equal;
      default:           cmp_result_o = 1'b0;
    endcase
  end

  always_comb begin
    result_o = 32'h0;
    case (operator_i)
      ALU_ADD: result_o = operand_a_i + operand_b_i;
      ALU_SUB: result_o = operand_a_i - operand_b_i;
      ALU_AND: result_o = operand_a_i & operand_b_i;
      ALU_OR:  result_o = operand_a_i | operand_b_i;
      ALU_XOR: result_o = operand_a_i ^ operand_b_i;
      ALU_SLL: result_o = operand_a_i << shamt;
      ALU_SRL: result_o = operand_a_i >> shamt;
      ALU_SRA: result_o = $unsigned($signed(operand_a_i) >>> shamt);
      ALU_LT, ALU_LTU, ALU_SLT, ALU_SLTU,
      ALU_GE, ALU_GEU, ALU_EQ, ALU_NE:
               result_o = {31'b0, cmp_result_o};
      ALU_SHA256SUM0, ALU_SHA256SUM1,
      ALU_SHA256SIG0, ALU_SHA256SIG1:
               result_o = sha_result;
      default: result_o = 32'h0;
    endcase
  end

  // Divider helpers ignore operator_i so the divider can use them in any cycle
  assign div_clz_result_o   = div_clz_en_i ? trailing_zeros(div_clz_data_rev_i) : 6'd0;
  assign div_op_b_shifted_o = (div_shift_en_i && !div_shift_amt_i[5])
                              ? (muldiv_operand_b_i << div_shift_amt_i[4:0]) : 32'h0;

endmodule

// File: tb/tb_cv32e40s_alu.sv
// tb/tb_cv32e40s_alu.sv - scoreboard bench for the combinational ALU
module tb_cv32e40s_alu;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst = 1'b1;
  logic [5:0]  operator_i = '0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic [31:0] muldiv_operand_b_i = '0;
  logic        div_clz_en_i = 1'b0;
  logic [31:0] div_clz_data_rev_i = '0;
  logic        div_shift_en_i = 1'b0;
  logic [5:0]  div_shift_amt_i = '0;
  logic [31:0] result_o;
  logic        cmp_result_o;
  logic [5:0]  div_clz_result_o;
  logic [31:0] div_op_b_shifted_o;

  typedef struct packed {
    logic [31:0] res;
    logic        cmp;
    logic [5:0]  clz;
    logic [31:0] shf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  cv32e40s_alu dut (
    .clk                (clk),
    .rst                (rst),
    .operator_i         (operator_i),
    .operand_a_i        (operand_a_i),
    .operand_b_i        (operand_b_i),
    .muldiv_operand_b_i (muldiv_operand_b_i),
    .div_clz_en_i       (div_clz_en_i),
    .div_clz_data_rev_i (div_clz_data_rev_i),
    .div_shift_en_i     (div_shift_en_i),
    .div_shift_amt_i    (div_shift_amt_i),
    .result_o           (result_o),
    .cmp_result_o       (cmp_result_o),
    .div_clz_result_o   (div_clz_result_o),
    .div_op_b_shifted_o (div_op_b_shifted_o)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  localparam logic [5:0] VALID_OPS [20] = '{
    6'b011000, 6'b011001, 6'b010101, 6'b101110, 6'b101111, 6'b100111, 6'b100101,
    6'b100100, 6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b001010, 6'b001011,
    6'b001100, 6'b001101, 6'b110110, 6'b111010, 6'b111011, 6'b111111};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic exp_t model();
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;
    logic        lts;
    logic        ltu;
    logic [63:0] wide;
    int          s;
    int          cnt;
    a   = operand_a_i;
    b   = operand_b_i;
    s   = int'(b[4:0]);
    lts = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    ltu = a < b;
    e   = '0;
    case (operator_i)
      6'b000000, 6'b000010: e.cmp = lts;
      6'b000001, 6'b000011: e.cmp = ltu;
      6'b001010: e.cmp = !lts;
      6'b001011: e.cmp = !ltu;
      6'b001100: e.cmp = (a == b);
      6'b001101: e.cmp = (a != b);
      default:   e.cmp = 1'b0;
    endcase
    case (operator_i)
      6'b011000: e.res = a + b;
      6'b011001: e.res = a + ~b + 32'd1;
      6'b010101: e.res = a & b;
      6'b101110: e.res = a | b;
      6'b101111: e.res = a ^ b;
      6'b100111: e.res = a << s;
      6'b100101: e.res = a >> s;
      6'b100100: e.res = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      6'b000000, 6'b000001, 6'b000010, 6'b000011,
      6'b001010, 6'b001011, 6'b001100, 6'b001101: e.res = {31'b0, e.cmp};
      6'b110110: e.res = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      6'b111010: e.res = ror(a, 6) ^ ror(a, 11) ^ ror(a, 25);
      6'b111011: e.res = ror(a, 7) ^ ror(a, 18) ^ (a >> 3);
      6'b111111: e.res = ror(a, 17) ^ ror(a, 19) ^ (a >> 10);
      default:   e.res = 32'h0;
    endcase
    cnt = 0;
    while (cnt < 32 && !div_clz_data_rev_i[cnt]) cnt++;
    e.clz = div_clz_en_i ? 6'(cnt) : 6'd0;
    wide  = {32'b0, muldiv_operand_b_i} << div_shift_amt_i;
    e.shf = div_shift_en_i ? wide[31:0] : 32'h0;
    return e;
  endfunction

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ce, input logic [31:0] rev, input logic se,
                       input logic [31:0] mb, input logic [5:0] amt);
    operator_i         = op;
    operand_a_i        = a;
    operand_b_i        = b;
    div_clz_en_i       = ce;
    div_clz_data_rev_i = rev;
    div_shift_en_i     = se;
    muldiv_operand_b_i = mb;
    div_shift_amt_i    = amt;
  endtask

  task automatic test_reset;
    exp_t e;
    exp_t got;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = (i < 2);
      drive(6'b011000, 32'd5, 32'd7, 1'b1, 32'h0000_0100, 1'b1, 32'h1, 6'd2);
      sb.push_back(exp_t'{res: 32'd12, cmp: 1'b0, clz: 6'd8, shf: 32'h4});
      #1;
      got = {result_o, cmp_result_o, div_clz_result_o, div_op_b_shifted_o};
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] rst=%0b: got %h expected %h", i, rst, got, e);
      end
    end
  endtask

  task automatic test_sha256;
    logic [5:0]  ops [4] = '{6'b110110, 6'b111010, 6'b111011, 6'b111111};
    logic [31:0] exp_r [4] = '{32'h6614_6474, 32'h3561_ABDA, 32'hE7FC_E6EE, 32'hA1F7_8649};
    exp_t e;
    exp_t got;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(ops[i % 4], 32'h1234_5678, (i < 4) ? 32'h0 : $urandom, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0);
      sb.push_back(exp_t'{res: exp_r[i % 4], cmp: 1'b0, clz: 6'd0, shf: 32'h0});
      #1;
      got = {result_o, cmp_result_o, div_clz_result_o, div_op_b_shifted_o};
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL sha256[%0d] op=%b b=%h: got %h expected %h", i, operator_i, operand_b_i, got, e);
      end
    end
  endtask

  task automatic test_arith_compare;
    logic [5:0]  ops [10] = '{6'b011000, 6'b100100, 6'b011001, 6'b100100, 6'b000000,
                              6'b000001, 6'b001010, 6'b001011, 6'b001100, 6'b000010};
    logic [31:0] as [10] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF};
    logic [31:0] bs [10] = '{32'h1, 32'h4, 32'h1, 32'h24, 32'h1, 32'h1, 32'h1, 32'h1, 32'h5, 32'h1};
    logic [31:0] rs [10] = '{32'h0, 32'hF800_0000, 32'hFFFF_FFFF, 32'hF800_0000, 32'h1,
                             32'h0, 32'h0, 32'h1, 32'h1, 32'h1};
    logic        cs [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_t e;
    exp_t got;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(ops[i], as[i], bs[i], 1'b0, 32'h0, 1'b0, 32'h0, 6'd0);
      sb.push_back(exp_t'{res: rs[i], cmp: cs[i], clz: 6'd0, shf: 32'h0});
      #1;
      got = {result_o, cmp_result_o, div_clz_result_o, div_op_b_shifted_o};
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL arith_cmp[%0d] op=%b: got %h expected %h", i, operator_i, got, e);
      end
    end
  endtask

  task automatic test_div;
    logic        ces [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] rev [7] = '{32'h8, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0, 32'h8000_0000};
    logic        ses [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [5:0]  amt [7] = '{6'd0, 6'd0, 6'd0, 6'd4, 6'd4, 6'd32, 6'd31};
    logic [5:0]  ez  [7] = '{6'd3, 6'd32, 6'd0, 6'd0, 6'd0, 6'd0, 6'd31};
    logic [31:0] es  [7] = '{32'h0, 32'h0, 32'h0, 32'h30, 32'h0, 32'h0, 32'h8000_0000};
    exp_t e;
    exp_t got;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(6'b010101, 32'h0, 32'h0, ces[i], rev[i], ses[i], 32'h3, amt[i]);
      sb.push_back(exp_t'{res: 32'h0, cmp: 1'b0, clz: ez[i], shf: es[i]});
      #1;
      got = {result_o, cmp_result_o, div_clz_result_o, div_op_b_shifted_o};
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL div[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_unlisted;
    logic [5:0] ops [4] = '{6'b000100, 6'b010000, 6'b111110, 6'b110111};
    exp_t e;
    exp_t got;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0);
      sb.push_back(exp_t'{res: 32'h0, cmp: 1'b0, clz: 6'd0, shf: 32'h0});
      #1;
      got = {result_o, cmp_result_o, div_clz_result_o, div_op_b_shifted_o};
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL unlisted[%0d] op=%b: got %h expected %h", i, operator_i, got, e);
      end
    end
  endtask

  task automatic test_random;
    exp_t        e;
    exp_t        got;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : VALID_OPS[$urandom_range(0, 19)];
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
      drive(op, a, b, 1'($urandom), ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom << $urandom_range(0, 31)),
            1'($urandom), $urandom, 6'($urandom));
      sb.push_back(model());
      #1;
      got = {result_o, cmp_result_o, div_clz_result_o, div_op_b_shifted_o};
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: got %h expected %h", i, op, a, b, got, e);
      end
    end
  endtask

  task automatic test_clock_stopped;
    exp_t e;
    exp_t got;
    @(negedge clk);
    clk_run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #3;
      rst = 1'($urandom);
      drive(VALID_OPS[$urandom_range(0, 19)], $urandom, $urandom, 1'b1, $urandom, 1'b1,
            $urandom, 6'($urandom_range(0, 40)));
      sb.push_back(model());
      #1;
      got = {result_o, cmp_result_o, div_clz_result_o, div_op_b_shifted_o};
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL clock_stopped[%0d] op=%b: got %h expected %h", i, operator_i, got, e);
      end
    end
    rst = 1'b0;
    clk_run = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sha256();
    test_arith_compare();
    test_div();
    test_unlisted();
    test_random();
    test_clock_stopped();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40s_alu.md
CV32E40S_ALU -- requirements
Module: cv32e40s_alu

Interface
REQ-001 clk  input  1  clock; present for interface uniformity; the datapath holds no state.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 operator_i  input  6  operation select, alu_opcode_e.
REQ-004 operand_a_i  input  32  first operand; the only source for SHA-256 ops.
REQ-005 operand_b_i  input  32  second operand / shift amount in bits [4:0].
REQ-006 muldiv_operand_b_i  input  32  divisor source for div shifter.
REQ-007 div_clz_en_i  input  1  enables leading-zero count for divider.
REQ-008 div_clz_data_rev_i  input  32  bit-reversed divider data.
REQ-009 div_shift_en_i  input  1  enables divisor shift.
REQ-010 div_shift_amt_i  input  6  divisor left-shift amount.
REQ-011 result_o  output  32  ALU result.
REQ-012 cmp_result_o  output  1  comparison result.
REQ-013 div_clz_result_o  output  6  leading-zero count.
REQ-014 div_op_b_shifted_o  output  32  shifted divisor.

Function
REQ-015 All outputs SHALL be purely combinational from inputs, zero latency; the SHA-256 ops SHALL ignore operand_b_i.
REQ-016 Encodings SHALL be: ADD 011000, SUB 011001, AND 010101, OR 101110, XOR 101111, SLL 100111, SRL 100101, SRA 100100, LT 000000, LTU 000001, SLT 000010, SLTU 000011, GE 001010, GEU 001011, EQ 001100, NE 001101, SHA256SUM0 110110, SHA256SUM1 111010, SHA256SIG0 111011, SHA256SIG1 111111.
REQ-017 ADD/SUB SHALL wrap modulo 2^32; logic ops bitwise; shifts use operand_b_i[4:0]; SRA sign-extends.
REQ-018 cmp_result_o SHALL give the signed/unsigned LT, GE, EQ, NE comparison of operand_a_i vs operand_b_i for compare opcodes, else 0; SLT/SLTU SHALL set result_o to zero-extended cmp result; LT/LTU/GE/GEU/EQ/NE SHALL drive result_o to the zero-extended cmp result.
REQ-019 With ror = rotate right and shr = logical shift right: SUM0 = ror(a,2)^ror(a,13)^ror(a,22).
REQ-020 SUM1 = ror(a,6)^ror(a,11)^ror(a,25).
REQ-021 SIG0 = ror(a,7)^ror(a,18)^shr(a,3).
REQ-022 SIG1 = ror(a,17)^ror(a,19)^shr(a,10).
REQ-023 Unlisted opcodes SHALL give result_o = 0 and cmp_result_o = 0.
REQ-024 div_clz_result_o SHALL equal the trailing-zero count of div_clz_data_rev_i (range 0..32; 32 when the input is zero) when div_clz_en_i=1, else 0.
REQ-025 div_op_b_shifted_o SHALL equal muldiv_operand_b_i << div_shift_amt_i when div_shift_en_i=1 (0 if amt >= 32), else 0.
REQ-026 Divider outputs SHALL be independent of operator_i.

Reset
REQ-027 The block SHALL contain no flip-flops; rst SHALL not affect any output, which therefore has no reset value beyond its combinational function.
REQ-028 Outputs SHALL be valid one delta after any input change, with clk stopped or running.

Structure
REQ-029 alu_opcode_e, including the four SHA-256 codes, SHALL live in cv32e40s_pkg.
REQ-030 The SHA-256 sigma functions SHALL be one sub-module cv32e40s_alu_sha256 (32-bit in, 2-bit select, 32-bit out).
REQ-031 The trailing-zero counter SHALL be an inline function or generate loop inside cv32e40s_alu.

Verification
REQ-032 Drive a = 0x12345678, b = 0, all div inputs 0:
  - SUM0 -> result_o = 0x66146474
  - SUM1 -> result_o = 0x3561ABDA
REQ-033 Same a:
  - SIG0 -> result_o = 0xE7FCE6EE
  - SIG1 -> result_o = 0xA1F78649
REQ-034 ADD 0xFFFFFFFF + 1 -> result_o = 0. SRA 0x80000000 by 4 -> result_o = 0xF8000000.
REQ-035 LT a=0xFFFFFFFF, b=1 -> cmp_result_o = 1; LTU with the same operands -> cmp_result_o = 0.
REQ-036 div_clz_en_i=1:
  - data_rev 0x00000008 -> div_clz_result_o = 3
  - data_rev 0 -> div_clz_result_o = 32
REQ-037 div_shift_en_i=1, muldiv_operand_b_i = 0x3, amt = 4 -> div_op_b_shifted_o = 0x30. Repeat with div_shift_en_i=0 -> 0.
